rcu_clkgen: RTL

Parametrised successor to the mini reset/clock unit: from one system clock, `rcu_clkgen` generates `NCH` independently programmable divided clocks, each with its own reset. A lock-qualified sequencer releases the channel resets in a fixed order. The block sits after the PLL/clock mux, in the `sys_clk` domain. It feeds peripheral subsystems that need slower clocks and staggered reset release.

---
 rtl/rcu_clkgen_pkg.sv | 13 +
 rtl/rcu_clkdiv_chan.sv | 66 ++++++
 rtl/rcu_clkgen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rcu_clkgen_pkg.sv
// Shared types and constants for the reset/clock generation unit.
package rcu_clkgen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rcu_seq_state_e;

  localparam int RCU_DIV_MIN = 2;

endpackage

// File: rtl/rcu_clkdiv_chan.sv
// One programmable clock-divider channel with shadowed divisor and glitch-free
// enable gating; divisor changes and disables only take effect at a period wrap.
module rcu_clkdiv_chan
  import rcu_clkgen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chan_rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             upd,
  output logic             div_clk
);

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] r);
    return (r < DIV_W'(RCU_DIV_MIN)) ? DIV_W'(RCU_DIV_MIN) : r;
  endfunction

  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] val_eff;
  logic [DIV_W-1:0] next_div;
  logic             run;
  logic             wrap;

  assign val_eff  = eff_div(div_val);
  // An update landing on the wrap cycle must win over the older shadow value.
  assign next_div = upd ? val_eff : shadow;
  assign cnt_inc  = cnt + DIV_W'(1);
  assign half     = active >> 1;
  assign wrap     = (cnt == active - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= DIV_W'(RCU_DIV_MIN);
      active  <= DIV_W'(RCU_DIV_MIN);
      cnt     <= '0;
      run     <= 1'b0;
      div_clk <= 1'b0;
    end else if (!chan_rst_n) begin
      shadow  <= val_eff;
      active  <= val_eff;
      cnt     <= '0;
      run     <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      if (upd) shadow <= val_eff;
      if (!run || wrap) begin
        // Period boundary: pick up the new divisor and start or stop cleanly.
        active  <= next_div;
        cnt     <= '0;
        run     <= en;
        div_clk <= en;
      end else begin
        cnt     <= cnt_inc;
        div_clk <= (cnt_inc < half);
      end
    end
  end

endmodule

// File: rtl/rcu_clkgen.sv
// Multi-channel clock divider with a lock-qualified sequencer that releases the
// per-channel resets in index order, RST_GAP cycles apart.
module rcu_clkgen
  import rcu_clkgen_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DIV_W    = 8,
  parameter int LOCK_CYC = 16,
  parameter int RST_GAP  = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pll_lock_i,
  input  logic [NCH-1:0]     div_en_i,
  input  logic [NCH*DIV_W-1:0] div_val_i,
  input  logic               div_upd_i,
  output logic [NCH-1:0]     div_clk_o,
  output logic [NCH-1:0]     div_rst_n_o,
  output logic               seq_done_o,
  output logic               lock_lost_o
);

  localparam int LK_W  = $clog2(LOCK_CYC + 1);
  localparam int GAP_W = $clog2(RST_GAP + 1);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  rcu_seq_state_e   state_q, state_d;
  logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [NCH-1:0]   rst_q, rst_d;
  logic             done_q, done_d;
  logic             lost_q, lost_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      rst_q      <= '0;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      rst_q      <= rst_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    gap_d      = gap_q;
    idx_d      = idx_q;
    rst_d      = rst_q;
    done_d     = done_q;
    lost_d     = 1'b0;
    idx_inc    = idx_q + IDX_W'(1);
    case (state_q)
      IDLE: begin
        rst_d      = '0;
        done_d     = 1'b0;
        lock_cnt_d = '0;
        if (pll_lock_i) state_d = STABLE;
      end
      STABLE: begin
        if (!pll_lock_i) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LK_W'(LOCK_CYC - 1)) begin
          rst_d[0] = 1'b1;
          gap_d    = '0;
          idx_d    = '0;
          if (NCH == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else if (lock_cnt_q != '1) begin
          lock_cnt_d = lock_cnt_q + LK_W'(1);
        end
      end
      RELEASE, RUN: begin
        // Lock loss outranks any release falling due on the same edge.
        if (!pll_lock_i) begin
          state_d    = IDLE;
          rst_d      = '0;
          done_d     = 1'b0;
          lost_d     = 1'b1;
          lock_cnt_d = '0;
        end else if (state_q == RELEASE) begin
          if (gap_q == GAP_W'(RST_GAP - 1)) begin
            gap_d = '0;
            idx_d = idx_inc;
            rst_d = rst_q | (NCH'(1) << idx_inc);
            if (idx_inc == IDX_W'(NCH - 1)) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_rst_n_o = rst_q;
  assign seq_done_o  = done_q;
  assign lock_lost_o = lost_q;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    rcu_clkdiv_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .chan_rst_n(rst_q[k]),
      .en        (div_en_i[k]),
      .div_val   (div_val_i[k*DIV_W +: DIV_W]),
      .upd       (div_upd_i),
      .div_clk   (div_clk_o[k])
    );
  end

endmodule
